// File: rtl/vec_pkg.sv
// Shared definitions for the vector execution units: reduction op encoding,
// default element width and the per-op identity/apply helpers.
package vec_pkg;

  localparam int DEF_ELEMENT_WIDTH = 32;

  typedef enum logic [1:0] {
    RED_SUM  = 2'd0,
    RED_MAXU = 2'd1,
    RED_MINU = 2'd2,
    RED_XOR  = 2'd3
  } red_op_e;

  // Value that leaves the accumulator unchanged for the given op.
  function automatic logic [DEF_ELEMENT_WIDTH-1:0] red_identity(input red_op_e op);
    logic [DEF_ELEMENT_WIDTH-1:0] id;
    id = (op == RED_MINU) ? {DEF_ELEMENT_WIDTH{1'b1}} : {DEF_ELEMENT_WIDTH{1'b0}};
    return id;
  endfunction

  // Two-operand reduction step; SUM wraps modulo 2^width.
  function automatic logic [DEF_ELEMENT_WIDTH-1:0] red_apply(
    input red_op_e                      op,
    input logic [DEF_ELEMENT_WIDTH-1:0] a,
    input logic [DEF_ELEMENT_WIDTH-1:0] b
  );
    logic [DEF_ELEMENT_WIDTH-1:0] r;
    case (op)
      RED_SUM:  r = a + b;
      RED_MAXU: r = (a > b) ? a : b;
      RED_MINU: r = (a < b) ? a : b;
      default:  r = a ^ b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vred_combine.sv
// Combinational tree reduction of one chunk of LANES elements. Masked-off
// lanes are replaced by the op identity so they do not disturb the result.
module vred_combine
  import vec_pkg::*;
#(
  parameter int LANES = 2,
  parameter int EW    = DEF_ELEMENT_WIDTH
) (
  input  logic [LANES-1:0][EW-1:0] elems_i,
  input  logic [LANES-1:0]         valid_i,
  input  red_op_e                  op_i,
  output logic [EW-1:0]            res_o
);

  // Tree is padded to a power of two; heap layout, leaves at P..2P-1.
  localparam int P = 1 << $clog2(LANES);

  logic [EW-1:0] ident;
  logic [EW-1:0] node [1:2*P-1];

  assign ident = EW'(red_identity(op_i));

  // Fill leaves (identity for masked/padded lanes), then fold pairwise up to the root.
  always_comb begin
    for (int i = 1; i < 2 * P; i++) begin
      node[i] = ident;
    end
    for (int j = 0; j < LANES; j++) begin
      node[P + j] = valid_i[j] ? elems_i[j] : ident;
    end
    for (int i = P - 1; i >= 1; i--) begin
      node[i] = red_apply(op_i, node[2 * i], node[2 * i + 1]);
    end
    res_o = node[1];
  end

endmodule

// File: rtl/vred_unit.sv
// Multi-cycle vector reduction stage. Captures a vector on start, folds LANES
// active elements per cycle into an accumulator, then pulses done with the
// scalar result, which is held until the next accepted start.
//
// Handshake: start_i is taken only while busy_o is low; once accepted, all
// inputs are ignored until done_o has pulsed and busy_o has dropped again.
module vred_unit
  import vec_pkg::*;
#(
  parameter  int VLEN          = 256,
  parameter  int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
  parameter  int LANES         = 2,
  localparam int ELEMS         = VLEN / ELEMENT_WIDTH,
  localparam int VLW           = $clog2(ELEMS) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [1:0]               op_i,
  input  logic [VLW-1:0]           vl_i,
  input  logic [ELEMENT_WIDTH-1:0] init_i,
  input  logic [VLEN-1:0]          vec_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ELEMENT_WIDTH-1:0] result_o
);

  localparam int CW         = $clog2(ELEMS / LANES) + 1;
  localparam int CHUNK_BITS = LANES * ELEMENT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [VLEN-1:0]          vec_q, vec_d;
  red_op_e                  op_q, op_d;
  logic [VLW-1:0]           vl_q, vl_d;
  logic [ELEMENT_WIDTH-1:0] acc_q, acc_d;
  logic [ELEMENT_WIDTH-1:0] result_q, result_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [VLW-1:0]                      vl_clamped;
  logic [VLEN-1:0]                     vec_sh;
  logic [LANES-1:0][ELEMENT_WIDTH-1:0] lane_elem;
  logic [LANES-1:0]                    lane_vld;
  logic [ELEMENT_WIDTH-1:0]            chunk_res;
  logic [ELEMENT_WIDTH-1:0]            acc_next;
  logic                                last_chunk;

  // Select the current chunk's lanes and mark those at or beyond vl inactive.
  always_comb begin
    vl_clamped = (vl_i > VLW'(ELEMS)) ? VLW'(ELEMS) : vl_i;
    vec_sh     = vec_q >> (int'(cnt_q) * CHUNK_BITS);
    for (int j = 0; j < LANES; j++) begin
      lane_elem[j] = vec_sh[j * ELEMENT_WIDTH +: ELEMENT_WIDTH];
      lane_vld[j]  = (int'(cnt_q) * LANES + j) < int'(vl_q);
    end
    last_chunk = ((int'(cnt_q) + 1) * LANES) >= int'(vl_q);
  end

  vred_combine #(
    .LANES (LANES),
    .EW    (ELEMENT_WIDTH)
  ) u_combine (
    .elems_i (lane_elem),
    .valid_i (lane_vld),
    .op_i    (op_q),
    .res_o   (chunk_res)
  );

  assign acc_next = red_apply(op_q, acc_q, chunk_res);

  // Next-state logic: latch on start, fold one chunk per RUN cycle, pulse in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    op_d     = op_q;
    vl_d     = vl_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          vec_d = vec_i;
          op_d  = red_op_e'(op_i);
          vl_d  = vl_clamped;
          acc_d = init_i;
          cnt_d = '0;
          if (vl_clamped != '0) begin
            state_d = ST_RUN;
          end else begin
            state_d  = ST_DONE;
            result_d = init_i;
          end
        end
      end
      ST_RUN: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CW'(1);
        if (last_chunk) begin
          state_d  = ST_DONE;
          result_d = acc_next;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      vec_q    <= '0;
      op_q     <= RED_SUM;
      vl_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      op_q     <= op_d;
      vl_q     <= vl_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_vred_unit.sv
// Self-checking bench for vred_unit at the default configuration.
module tb_vred_unit;

  localparam int VLEN  = 256;
  localparam int EW    = 32;
  localparam int ELEMS = 8;
  localparam int LANES = 2;
  localparam int VLW   = 4;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [1:0]      op;
  logic [VLW-1:0]  vl;
  logic [EW-1:0]   init;
  logic [VLEN-1:0] vec;
  logic            busy;
  logic            done;
  logic [EW-1:0]   result;

  int checks;
  int errors;
  logic [EW-1:0] exp_q[$];

  vred_unit #(
    .VLEN          (VLEN),
    .ELEMENT_WIDTH (EW),
    .LANES         (LANES)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .op_i     (op),
    .vl_i     (vl),
    .init_i   (init),
    .vec_i    (vec),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sequential fold over the active elements.
  function automatic logic [EW-1:0] model_red(input logic [1:0] m_op, input int m_vl,
                                               input logic [EW-1:0] m_init,
                                               input logic [VLEN-1:0] m_vec);
    int n;
    logic [EW-1:0] acc;
    logic [EW-1:0] e;
    n   = (m_vl > ELEMS) ? ELEMS : m_vl;
    acc = m_init;
    for (int i = 0; i < n; i++) begin
      e = m_vec[i*EW +: EW];
      case (m_op)
        2'd0: acc = acc + e;
        2'd1: acc = (e > acc) ? e : acc;
        2'd2: acc = (e < acc) ? e : acc;
        default: acc = acc ^ e;
      endcase
    end
    return acc;
  endfunction

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < ELEMS; i++) v[i*EW +: EW] = $urandom;
    return v;
  endfunction

  // Driver: issue one operation and watch it complete. restart_at > 0 pulses a
  // second start (different vector) in that cycle, which must be ignored.
  task automatic run_and_check(input logic [1:0] t_op, input int t_vl, input logic [EW-1:0] t_init,
                               input logic [VLEN-1:0] t_vec, input string name, input int restart_at);
    int n_eff, n_chunks, done_cnt, done_cyc, busy_bad;
    logic [EW-1:0] exp_val, got, popped;
    n_eff    = (t_vl > ELEMS) ? ELEMS : t_vl;
    n_chunks = (n_eff + LANES - 1) / LANES;
    exp_q.push_back(model_red(t_op, t_vl, t_init, t_vec));
    exp_val  = model_red(t_op, t_vl, t_init, t_vec);
    @(negedge clk);
    start = 1'b1; op = t_op; vl = VLW'(t_vl); init = t_init; vec = t_vec;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); vl = VLW'($urandom); init = $urandom; vec = rand_vec();
    done_cnt = 0; done_cyc = -1; busy_bad = 0; got = '0;
    for (int c = 1; c <= n_chunks + 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          got = result;
          popped = (exp_q.size() > 0) ? exp_q.pop_front() : ~exp_val;
          checks++;
          if (got !== popped) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, got, popped);
          end
        end
      end
      if (busy !== ((c <= n_chunks + 1) ? 1'b1 : 1'b0)) busy_bad++;
      if (c == restart_at) begin
        start = 1'b1; vec = rand_vec(); init = $urandom; op = 2'($urandom); vl = 4'd8;
      end
    end
    start = 1'b0;
    checks++;
    if (done_cyc != n_chunks + 1) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, n_chunks + 1);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy_window: %0d bad cycles expected 0", name, busy_bad);
    end
    checks++;
    if (result !== exp_val) begin
      errors++;
      $display("FAIL %s result_held: got %h expected %h", name, result, exp_val);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = '0; vl = '0; init = '0; vec = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_state: busy %b done %b result %h expected 0 0 0", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sum_basic();
    logic [VLEN-1:0] v;
    for (int i = 0; i < ELEMS; i++) v[i*EW +: EW] = EW'(i + 1);
    run_and_check(2'd0, 8, 32'd0, v, "sum_1_to_8", 0);
    checks++;
    if (result !== 32'h24) begin
      errors++;
      $display("FAIL sum_const: got %h expected 00000024", result);
    end
  endtask

  task automatic test_maxu_masked();
    logic [VLEN-1:0] v;
    int vals[8] = '{5, 9, 2, 100, 7, 7, 7, 7};
    for (int i = 0; i < ELEMS; i++) v[i*EW +: EW] = EW'(vals[i]);
    run_and_check(2'd1, 3, 32'd0, v, "maxu_vl3", 0);
    checks++;
    if (result !== 32'd9) begin
      errors++;
      $display("FAIL maxu_const: got %h expected 00000009", result);
    end
  endtask

  task automatic test_vl_bounds();
    logic [VLEN-1:0] v;
    logic [EW-1:0] r8;
    v = rand_vec();
    run_and_check(2'd2, 0, 32'h10, v, "minu_vl0", 0);
    run_and_check(2'd2, 8, 32'hFFFF_FFFF, v, "minu_vl8", 0);
    r8 = result;
    run_and_check(2'd2, 15, 32'hFFFF_FFFF, v, "minu_vl15", 0);
    checks++;
    if (result !== r8) begin
      errors++;
      $display("FAIL vl15_vs_vl8: got %h expected %h", result, r8);
    end
  endtask

  task automatic test_wrap_xor();
    logic [VLEN-1:0] v;
    v = '0;
    v[0 +: EW] = 32'hFFFF_FFFF;
    v[EW +: EW] = 32'd2;
    run_and_check(2'd0, 8, 32'd0, v, "sum_wrap", 0);
    checks++;
    if (result !== 32'd1) begin
      errors++;
      $display("FAIL wrap_const: got %h expected 00000001", result);
    end
    v = rand_vec();
    v[0 +: EW] = 32'hA5A5_A5A5;
    v[EW +: EW] = 32'h5A5A_5A5A;
    run_and_check(2'd3, 2, 32'd0, v, "xor_pair", 0);
    checks++;
    if (result !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL xor_const: got %h expected ffffffff", result);
    end
  endtask

  task automatic test_start_while_busy();
    run_and_check(2'd0, 8, $urandom, rand_vec(), "restart_ignored", 2);
  endtask

  task automatic test_reset_mid_run();
    logic [VLEN-1:0] v;
    int stray;
    v = rand_vec();
    @(negedge clk);
    start = 1'b1; op = 2'd0; vl = 4'd8; init = 32'd7; vec = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: busy %b done %b result %h expected 0 0 0", busy, done, result);
    end
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) stray++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_no_stray: got %0d activity cycles expected 0", stray);
    end
    run_and_check(2'd0, 8, 32'd3, v, "after_reset", 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      run_and_check(2'($urandom), int'($urandom_range(0, 15)), $urandom, rand_vec(), "random", 0);
    end
  endtask

  task automatic test_back_to_back();
    // Next start issued as soon as busy drops; run_and_check returns in that state.
    run_and_check(2'd3, 7, $urandom, rand_vec(), "b2b_a", 0);
    run_and_check(2'd1, 5, $urandom, rand_vec(), "b2b_b", 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sum_basic();
    test_maxu_masked();
    test_vl_bounds();
    test_wrap_xor();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

endmodule
